fifo_stream_adapter: RTL and testbench

- Read-side consumer of the dual-clock FIFO, placed in the read clock domain.
- Converts the FIFO's fixed-latency read interface (read enable, empty flag, read data returned RD_LATENCY cycles later) into a valid/ready stream.
- Uses credit-based prefetch into a small circular skid buffer, giving downstream logic zero-latency data with full 1-word/cycle throughput.

---
 rtl/fifo_stream_adapter_if.sv | 36 +++
 rtl/fifo_stream_adapter.sv | 106 ++++++++++
 tb/tb_fifo_stream_adapter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_adapter_if.sv
// Read-side bundle for fifo_stream_adapter: FIFO read port plus the valid/ready stream.
// master = adapter side, slave = FIFO/downstream side.
interface fifo_stream_adapter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 4
);
  localparam int LEVEL_W = $clog2(BUF_DEPTH) + 1;

  logic                  o_fifo_re;
  logic                  i_fifo_empty;
  logic [DATA_WIDTH-1:0] i_fifo_rdata;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic [LEVEL_W-1:0]    o_level;

  modport master (
    output o_fifo_re,
    input  i_fifo_empty,
    input  i_fifo_rdata,
    output o_valid,
    input  i_ready,
    output o_data,
    output o_level
  );

  modport slave (
    input  o_fifo_re,
    output i_fifo_empty,
    output i_fifo_rdata,
    input  o_valid,
    output i_ready,
    input  o_data,
    input  o_level
  );
endinterface

// File: rtl/fifo_stream_adapter.sv
// Turns a fixed-latency FIFO read port into a zero-latency valid/ready stream using credit-based prefetch.
// Optional starvation counter (o_starve_cnt) enabled by defining FIFO_STREAM_ADAPTER_STALL_CNT_EN.
module fifo_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  fifo_stream_adapter_if.master bus
`ifdef FIFO_STREAM_ADAPTER_STALL_CNT_EN
  ,
  output logic [15:0]           o_starve_cnt
`endif
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      rptr_reg;
  logic [PTR_W-1:0]      wptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic [RD_LATENCY-1:0] pipe_reg;
  logic [RD_LATENCY-1:0] pipe_next;
  logic [CNT_W-1:0]      inflight;
  logic [SUM_W-1:0]      credit_used;
  logic                  fifo_re;
  logic                  acc;
  logic                  capture;
  logic                  valid;
  logic                  pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(pipe_reg[i]);
    end
  end

  // Credit uses registered state only, so the request never waits on the empty flag.
  assign credit_used = SUM_W'(count_reg) + SUM_W'(inflight);
  assign fifo_re     = ~i_rst & (credit_used < SUM_W'(BUF_DEPTH));
  assign acc         = fifo_re & ~bus.i_fifo_empty;
  assign capture     = pipe_reg[RD_LATENCY-1];
  assign valid       = ~i_rst & (count_reg != '0);
  assign pop         = valid & bus.i_ready;
  assign count_next  = count_reg + CNT_W'(capture) - CNT_W'(pop);

  generate
    for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_next[gi] = acc;
      end else begin : g_stage
        assign pipe_next[gi] = pipe_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_reg <= '0;
      rptr_reg  <= '0;
      wptr_reg  <= '0;
      pipe_reg  <= '0;
    end else begin
      count_reg <= count_next;
      pipe_reg  <= pipe_next;
      if (capture) begin
        wptr_reg <= wptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rptr_reg <= rptr_reg + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && capture) begin
      buf_mem[wptr_reg] <= bus.i_fifo_rdata;
    end
  end

  assign bus.o_fifo_re = fifo_re;
  assign bus.o_valid   = valid;
  assign bus.o_data    = buf_mem[rptr_reg];
  assign bus.o_level   = i_rst ? '0 : count_reg;

  // Buffered plus requested words must never exceed the buffer.
  assert property (@(posedge i_clk) disable iff (i_rst) credit_used <= SUM_W'(BUF_DEPTH));

`ifdef FIFO_STREAM_ADAPTER_STALL_CNT_EN
  logic [15:0] starve_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt_reg <= '0;
    end else if (bus.i_ready && !valid && (credit_used == '0) && (starve_cnt_reg != 16'hFFFF)) begin
      starve_cnt_reg <= starve_cnt_reg + 16'd1;
    end
  end

  assign o_starve_cnt = starve_cnt_reg;
`endif
endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Directed bench for fifo_stream_adapter: one instance with RD_LATENCY=1, one with RD_LATENCY=2.
// Each instance is fed by a small FIFO model with configurable read latency and empty gaps.
module tb_fifo_stream_adapter;
  localparam int DW = 8;
  localparam int BD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_stream_adapter_if #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) a_if ();
  fifo_stream_adapter_if #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) b_if ();

`ifdef FIFO_STREAM_ADAPTER_STALL_CNT_EN
  logic [15:0] starve_a;
  logic [15:0] starve_b;
`endif

  fifo_stream_adapter #(.DATA_WIDTH(DW), .RD_LATENCY(1), .BUF_DEPTH(BD)) u_a (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (a_if)
`ifdef FIFO_STREAM_ADAPTER_STALL_CNT_EN
    ,
    .o_starve_cnt(starve_a)
`endif
  );

  fifo_stream_adapter #(.DATA_WIDTH(DW), .RD_LATENCY(2), .BUF_DEPTH(BD)) u_b (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (b_if)
`ifdef FIFO_STREAM_ADAPTER_STALL_CNT_EN
    ,
    .o_starve_cnt(starve_b)
`endif
  );

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] refq[$];
  logic [7:0] pipe_b;
  logic       gap_a;
  logic       gap_b;
  int         reads_a;
  int         reads_b;
  int         checks;
  int         passes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_empty();
    a_if.i_fifo_empty = gap_a || (qa.size() == 0);
    b_if.i_fifo_empty = gap_b || (qb.size() == 0);
  endtask

  // One clock: sample accepted reads before the edge, return FIFO data after it.
  task automatic step();
    logic acc_a;
    logic acc_b;
    #1;
    acc_a = (a_if.o_fifo_re === 1'b1) && (a_if.i_fifo_empty === 1'b0);
    acc_b = (b_if.o_fifo_re === 1'b1) && (b_if.i_fifo_empty === 1'b0);
    @(posedge clk);
    #1;
    if (acc_a && qa.size() > 0) begin
      a_if.i_fifo_rdata = qa.pop_front();
      reads_a++;
    end
    b_if.i_fifo_rdata = pipe_b;
    if (acc_b && qb.size() > 0) begin
      pipe_b = qb.pop_front();
      reads_b++;
    end
    update_empty();
  endtask

  initial begin
    int         n;
    int         popped;
    int         errs;
    logic [7:0] w;
    logic [7:0] e;

    checks = 0;
    passes = 0;
    reads_a = 0;
    reads_b = 0;
    gap_a = 1'b0;
    gap_b = 1'b0;
    pipe_b = 8'h00;
    rst = 1'b1;
    a_if.i_ready = 1'b0;
    b_if.i_ready = 1'b0;
    a_if.i_fifo_rdata = 8'h00;
    b_if.i_fifo_rdata = 8'h00;
    update_empty();

    // Reset, FIFO empty
    step();
    step();
    chk("rst_valid", a_if.o_valid, 1'b0);
    chk("rst_level", a_if.o_level, 3'd0);
    chk("rst_fifo_re", a_if.o_fifo_re, 1'b0);
    chk("rst_fifo_re_b", b_if.o_fifo_re, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_fifo_re", a_if.o_fifo_re, 1'b1);
    chk("post_rst_valid", a_if.o_valid, 1'b0);
    chk("post_rst_level", a_if.o_level, 3'd0);
    $display("reset: fifo_re=%0b valid=%0b level=%0d", a_if.o_fifo_re, a_if.o_valid, a_if.o_level);

    // Three words, ready held high, RD_LATENCY=1
    qa.push_back(8'h11);
    qa.push_back(8'h22);
    qa.push_back(8'h33);
    a_if.i_ready = 1'b1;
    update_empty();
    #1;
    chk("three_c0_valid", a_if.o_valid, 1'b0);
    step();
    chk("three_c1_valid", a_if.o_valid, 1'b0);
    step();
    chk("three_c2_valid", a_if.o_valid, 1'b1);
    chk("three_c2_data", a_if.o_data, 8'h11);
    step();
    chk("three_c3_valid", a_if.o_valid, 1'b1);
    chk("three_c3_data", a_if.o_data, 8'h22);
    step();
    chk("three_c4_valid", a_if.o_valid, 1'b1);
    chk("three_c4_data", a_if.o_data, 8'h33);
    step();
    chk("three_c5_valid", a_if.o_valid, 1'b0);
    $display("three words: done, reads=%0d", reads_a);

    // 100 words with RD_LATENCY=2 at full throughput
    for (int i = 0; i < 100; i++) qb.push_back(i[7:0]);
    b_if.i_ready = 1'b1;
    update_empty();
    n = 0;
    #1;
    while (b_if.o_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("l2_first_latency", n, 3);
    for (int i = 0; i < 100; i++) begin
      chk("l2_stream_valid", b_if.o_valid, 1'b1);
      chk("l2_stream_data", b_if.o_data, i[7:0]);
      step();
    end
    chk("l2_drained", b_if.o_valid, 1'b0);
    b_if.i_ready = 1'b0;
    $display("l2 stream: 100 words, first latency=%0d", n);

    // Downstream stall with 10 words
    reads_a = 0;
    a_if.i_ready = 1'b0;
    for (int i = 0; i < 10; i++) qa.push_back(8'hA0 + i[7:0]);
    update_empty();
    repeat (12) step();
    chk("stall_level", a_if.o_level, 3'd4);
    chk("stall_fifo_re", a_if.o_fifo_re, 1'b0);
    chk("stall_reads", reads_a, 4);
    chk("stall_valid", a_if.o_valid, 1'b1);
    chk("stall_data", a_if.o_data, 8'hA0);
    step();
    step();
    chk("stall_hold_data", a_if.o_data, 8'hA0);
    chk("stall_hold_reads", reads_a, 4);
    a_if.i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      #1;
      while (a_if.o_valid !== 1'b1 && n < 8) begin
        step();
        n++;
      end
      e = 8'hA0 + k[7:0];
      chk("stall_drain_valid", a_if.o_valid, 1'b1);
      chk("stall_drain_data", a_if.o_data, e);
      step();
    end
    step();
    chk("stall_after_valid", a_if.o_valid, 1'b0);
    chk("stall_total_reads", reads_a, 10);
    a_if.i_ready = 1'b0;
    $display("stall: level peaked at 4, reads=%0d", reads_a);

    // Random ready and random FIFO empty gaps, 10k words
    for (int i = 0; i < 10000; i++) begin
      w = 8'($urandom);
      qb.push_back(w);
      refq.push_back(w);
    end
    popped = 0;
    errs = 0;
    for (int c = 0; c < 60000 && popped < 10000; c++) begin
      gap_b = ($urandom_range(3) == 0);
      b_if.i_ready = 1'($urandom_range(1));
      update_empty();
      #1;
      if (b_if.o_valid === 1'b1 && b_if.i_ready === 1'b1) begin
        if (refq.size() > 0) begin
          e = refq.pop_front();
          if (b_if.o_data !== e) errs++;
        end else begin
          errs++;
        end
        popped++;
      end
      if (b_if.o_level > 3'(BD)) errs++;
      step();
    end
    chk("rand_popped", popped, 10000);
    chk("rand_errs", errs, 0);
    gap_b = 1'b0;
    b_if.i_ready = 1'b0;
    update_empty();
    $display("random: popped=%0d errors=%0d", popped, errs);

    // Reset pulse with two reads in flight (RD_LATENCY=2)
    for (int i = 0; i < 5; i++) qb.push_back(8'hC0 + i[7:0]);
    update_empty();
    step();
    step();
    rst = 1'b1;
    qb.delete();
    b_if.i_ready = 1'b1;
    update_empty();
    step();
    rst = 1'b0;
    #1;
    chk("midrst_valid", b_if.o_valid, 1'b0);
    chk("midrst_level", b_if.o_level, 3'd0);
`ifdef FIFO_STREAM_ADAPTER_STALL_CNT_EN
    chk("midrst_starve0", starve_b, 16'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_capture", b_if.o_level, 3'd0);
    end
`ifdef FIFO_STREAM_ADAPTER_STALL_CNT_EN
    chk("midrst_starve3", starve_b, 16'd3);
`endif
    $display("mid reset: level=%0d valid=%0b", b_if.o_level, b_if.o_valid);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
